ysyx_22050133_ifu: RTL and testbench

Instruction fetch stage of the ysyx_22050133 pipelined RV64 core, directly upstream of the decode stage. Owns the PC and issues one 32-bit fetch at a time over a valid/ready request, fixed-response instruction-memory port. Accepts PC redirects from the execute/memory stages and holds its output under the decode-stage load-use stall. Presents a registered IF/ID bundle (`pc`, `inst`, `valid`) to decode.

---
 rtl/ysyx_22050133_ifu_pkg.sv | 29 ++
 rtl/ysyx_22050133_ifid_reg.sv | 40 ++++
 rtl/ysyx_22050133_ifu.sv | 170 +++++++++++++++++
 tb/tb_ysyx_22050133_ifu.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050133_ifu_pkg.sv
// ysyx_22050133_ifu_pkg
//   Shared definitions for the instruction fetch stage:
//   - fetch FSM state encoding (ST_FAULT only with YSYX_22050133_IFU_MISALIGN_EN)
//   - RESET_PC default, NOP encoding, IF/ID bundle layout and width
package ysyx_22050133_ifu_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
`ifdef YSYX_22050133_IFU_MISALIGN_EN
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
`else
        ST_HOLD  = 2'd2
`endif
    } ifu_state_t;

    // IF/ID payload; valid travels separately so flush can clear it alone.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ifid_t;

    localparam int IFID_W = $bits(ifid_t);

endpackage

// File: rtl/ysyx_22050133_ifid_reg.sv
// ysyx_22050133_ifid_reg
//   IF/ID pipeline register with load / hold / flush.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     flush           clear valid (highest priority after reset)
//     load            capture load_bundle and set valid
//     stall           hold everything while valid is set
//     load_bundle     {pc, inst} to capture
//     valid, bundle   registered outputs
module ysyx_22050133_ifid_reg
    import ysyx_22050133_ifu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              stall,
    input  logic [IFID_W-1:0] load_bundle,
    output logic              valid,
    output logic [IFID_W-1:0] bundle
);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            bundle <= {64'h0, INST_NOP};
        end else if (flush) begin
            valid  <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            bundle <= load_bundle;
        end else if (!(stall && valid)) begin
            // Nothing new and not held: the slot empties, payload is don't-care.
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_22050133_ifu.sv
// ysyx_22050133_ifu
//   Instruction fetch stage: owns the PC, issues one fetch at a time on a
//   valid/ready request port with a fixed (non-stallable) response, and
//   presents a registered IF/ID bundle to decode.
//   Optional feature macro: YSYX_22050133_IFU_MISALIGN_EN (misaligned
//   redirect enters FAULT and raises id_misalign; otherwise the redirect
//   target is word-aligned by clearing bits [1:0]).
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     redirect_valid, redirect_pc  PC redirect (priority over everything)
//     stall                        decode hazard; hold IF/ID
//     imem_req_valid/ready/addr    fetch request
//     imem_resp_valid/data         fetch response (must be accepted)
//     id_valid, id_pc, id_inst     IF/ID bundle
//     id_misalign                  fault flag (macro only)
module ysyx_22050133_ifu
    import ysyx_22050133_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
`ifdef YSYX_22050133_IFU_MISALIGN_EN
    output logic        id_misalign,
`endif
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [31:0] id_inst
);

    ifu_state_t        state, state_n;
    logic [63:0]       pc, pc_n;
    logic              drop, drop_n;
    logic [31:0]       buf_inst;
    logic              buf_we;
    logic              ifid_load, ifid_flush;
    logic [IFID_W-1:0] ifid_in;
    logic [63:0]       redir_target;
    logic              resp_pending;

`ifdef YSYX_22050133_IFU_MISALIGN_EN
    assign redir_target = redirect_pc;
    assign id_misalign  = (state == ST_FAULT);
`else
    assign redir_target = {redirect_pc[63:2], 2'b00};
`endif

    // Outputs depend on registered state only.
    assign imem_req_valid = (state == ST_REQ);
    assign imem_req_addr  = pc;

    // On a redirect, is a (now stale) response still owed by memory after
    // this cycle? A response arriving in the redirect cycle is consumed and
    // discarded right away, so nothing is left to drop afterwards.
    always_comb begin
        resp_pending = 1'b0;
        case (state)
            ST_REQ:   resp_pending = imem_req_ready;
            ST_WAIT:  resp_pending = !imem_resp_valid;
`ifdef YSYX_22050133_IFU_MISALIGN_EN
            ST_FAULT: resp_pending = drop && !imem_resp_valid;
`endif
            default:  resp_pending = 1'b0;
        endcase
    end

    // NOTE: every signal gets a default before any branch so this block
    // stays purely combinational (no inferred latches).
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        drop_n     = drop;
        buf_we     = 1'b0;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_in    = {pc, imem_resp_data};

        if (redirect_valid) begin
            ifid_flush = 1'b1;
            pc_n       = redir_target;
            drop_n     = resp_pending;
            state_n    = resp_pending ? ST_WAIT : ST_REQ;
`ifdef YSYX_22050133_IFU_MISALIGN_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_n = ST_FAULT;
            end
`endif
        end else begin
            case (state)
                ST_REQ: begin
                    if (imem_req_ready) begin
                        state_n = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop) begin
                            drop_n  = 1'b0;
                            state_n = ST_REQ;
                        end else if (!id_valid || !stall) begin
                            ifid_load = 1'b1;
                            pc_n      = pc + 64'd4;
                            state_n   = ST_REQ;
                        end else begin
                            buf_we  = 1'b1;
                            state_n = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_load = 1'b1;
                        ifid_in   = {pc, buf_inst};
                        pc_n      = pc + 64'd4;
                        state_n   = ST_REQ;
                    end
                end
`ifdef YSYX_22050133_IFU_MISALIGN_EN
                ST_FAULT: begin
                    // Swallow a stale response that was in flight at entry.
                    if (imem_resp_valid) begin
                        drop_n = 1'b0;
                    end
                end
`endif
                default: state_n = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_REQ;
            pc    <= RESET_PC;
            drop  <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            drop  <= drop_n;
        end
    end

    // NOTE: the skid buffer is data-only; it is never read unless HOLD was
    // entered through a write, so it needs no reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_inst <= imem_resp_data;
        end
    end

    ysyx_22050133_ifid_reg u_ifid_reg (
        .clk         (clk),
        .rst         (rst),
        .flush       (ifid_flush),
        .load        (ifid_load),
        .stall       (stall),
        .load_bundle (ifid_in),
        .valid       (id_valid),
        .bundle      ({id_pc, id_inst})
    );

endmodule

// File: tb/tb_ysyx_22050133_ifu.sv
// tb_ysyx_22050133_ifu
//   Directed scenarios followed by a randomized run against a transaction
//   level model: expected fetch address, one outstanding fetch, and a queue
//   of words owed to decode in order.
module tb_ysyx_22050133_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_inst;
`ifdef YSYX_22050133_IFU_MISALIGN_EN
    logic        id_misalign;
`endif

    always #5 clk = ~clk;

    ysyx_22050133_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
`ifdef YSYX_22050133_IFU_MISALIGN_EN
        .id_misalign     (id_misalign),
`endif
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_inst         (id_inst)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- reference model state ----------------
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } deliv_t;

    deliv_t      owed[$];
    logic [63:0] exp_pc;
    bit          out_active;
    bit          out_killed;
    logic [63:0] out_addr;
    int          out_cnt;
    bit          exp_hold;
    logic [63:0] hold_pc;
    logic [31:0] hold_inst;

    task automatic model_cycle(input bit quiet);
        deliv_t      d;
        bit          rdr, stl, rdy, rsp, hs;
        logic [63:0] tgt;
        logic [31:0] data;

        // Outcome of the edge just taken.
        if (exp_hold) begin
            check("hold_valid", 64'(id_valid), 64'd1);
            check("hold_pc", id_pc, hold_pc);
            check("hold_inst", 64'(id_inst), 64'(hold_inst));
        end else if (id_valid) begin
            if (owed.size() == 0) begin
                check("spurious_valid", 64'(id_valid), 64'd0);
            end else begin
                d = owed.pop_front();
                check("rand_id_pc", id_pc, d.pc);
                check("rand_id_inst", 64'(id_inst), 64'(d.inst));
            end
        end

        // Memory: response after the chosen latency.
        rsp  = 1'b0;
        data = $urandom;
        if (out_active) begin
            check("req_while_busy", 64'(imem_req_valid), 64'd0);
            out_cnt--;
            if (out_cnt == 0) rsp = 1'b1;
        end

        rdr = !quiet && ($urandom_range(0, 15) == 0);
        tgt = 64'h8000_0000 + (64'($urandom_range(0, 1023)) << 2);
        stl = !quiet && ($urandom_range(0, 2) == 0);
        rdy = !quiet && ($urandom_range(0, 1) == 1);
        hs  = imem_req_valid && rdy;

        if (hs) check("rand_req_addr", imem_req_addr, exp_pc);
        if (rdr) begin
            out_killed = 1'b1;
            owed.delete();
            exp_pc = tgt;
        end
        if (rsp) begin
            out_active = 1'b0;
            if (!out_killed) begin
                d.pc   = out_addr;
                d.inst = data;
                owed.push_back(d);
                exp_pc = out_addr + 64'd4;
            end
        end
        if (hs) begin
            out_active = 1'b1;
            out_killed = rdr;
            out_addr   = imem_req_addr;
            out_cnt    = $urandom_range(1, 3);
        end
        exp_hold  = stl && id_valid && !rdr;
        hold_pc   = id_pc;
        hold_inst = id_inst;

        redirect_valid  = rdr;
        redirect_pc     = tgt;
        stall           = stl;
        imem_req_ready  = rdy;
        imem_resp_valid = rsp;
        imem_resp_data  = rsp ? data : 32'h0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 64'h0;
        stall = 1'b0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;
        @(negedge clk);
        tick();
        tick();

        // Reset values
        check("rst_id_valid", 64'(id_valid), 64'd0);
        check("rst_id_pc", id_pc, 64'h0);
        check("rst_id_inst", 64'(id_inst), 64'h13);
        check("rst_req_valid", 64'(imem_req_valid), 64'd1);
        check("rst_req_addr", imem_req_addr, 64'h8000_0000);
        rst = 1'b0;

        // First fetch: handshake, response one cycle later, bundle next cycle
        imem_req_ready = 1'b1;
        tick();
        check("wait_no_req", 64'(imem_req_valid), 64'd0);
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h0000_0093;
        tick();
        imem_resp_valid = 1'b0;
        check("ff_id_valid", 64'(id_valid), 64'd1);
        check("ff_id_pc", id_pc, 64'h8000_0000);
        check("ff_id_inst", 64'(id_inst), 64'h93);
        check("ff_next_addr", imem_req_addr, 64'h8000_0004);

        // Stall with buffer
        stall = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h0000_AAAA;
        tick();
        imem_resp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("st_id_valid", 64'(id_valid), 64'd1);
            check("st_id_pc", id_pc, 64'h8000_0000);
            check("st_id_inst", 64'(id_inst), 64'h93);
            check("st_no_req", 64'(imem_req_valid), 64'd0);
            tick();
        end
        stall = 1'b0;
        tick();
        check("unst_id_valid", 64'(id_valid), 64'd1);
        check("unst_id_pc", id_pc, 64'h8000_0004);
        check("unst_id_inst", 64'(id_inst), 64'hAAAA);
        check("unst_next_addr", imem_req_addr, 64'h8000_0008);

        // Redirect while waiting
        imem_req_ready = 1'b1;
        tick();
        check("empty_id_valid", 64'(id_valid), 64'd0);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h0000_BBBB;
        tick();
        imem_resp_valid = 1'b0;
        check("rw_id_valid", 64'(id_valid), 64'd0);
        check("rw_req_valid", 64'(imem_req_valid), 64'd1);
        check("rw_req_addr", imem_req_addr, 64'h8000_0100);

        // Redirect with simultaneous handshake
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0300;
        tick();
        check("rh_no_req", 64'(imem_req_valid), 64'd0);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h0000_CCCC;
        tick();
        imem_resp_valid = 1'b0;
        check("rh_id_valid", 64'(id_valid), 64'd0);
        check("rh_req_addr", imem_req_addr, 64'h8000_0300);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0102;
        tick();
        redirect_valid = 1'b0;
`ifdef YSYX_22050133_IFU_MISALIGN_EN
        imem_req_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("mis_flag", 64'(id_misalign), 64'd1);
            check("mis_no_req", 64'(imem_req_valid), 64'd0);
            check("mis_id_valid", 64'(id_valid), 64'd0);
            tick();
        end
        imem_req_ready = 1'b0;
`else
        check("mis_req_valid", 64'(imem_req_valid), 64'd1);
        check("mis_aligned_addr", imem_req_addr, 64'h8000_0100);
`endif
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0200;
        tick();
        redirect_valid = 1'b0;
`ifdef YSYX_22050133_IFU_MISALIGN_EN
        check("mis_cleared", 64'(id_misalign), 64'd0);
`endif
        check("mis_resume_valid", 64'(imem_req_valid), 64'd1);
        check("mis_resume_addr", imem_req_addr, 64'h8000_0200);

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("wrap_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h1234_5678;
        tick();
        imem_resp_valid = 1'b0;
        check("wrap_id_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_id_inst", 64'(id_inst), 64'h1234_5678);
        check("wrap_next_addr", imem_req_addr, 64'h0);

        // Randomized run from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_id_valid", 64'(id_valid), 64'd0);
        check("rst2_req_addr", imem_req_addr, 64'h8000_0000);
        owed.delete();
        exp_pc = 64'h8000_0000;
        out_active = 1'b0;
        out_killed = 1'b0;
        out_addr = 64'h0;
        out_cnt = 0;
        exp_hold = 1'b0;
        hold_pc = 64'h0;
        hold_inst = 32'h0;
        for (int i = 0; i < 4000; i++) model_cycle(1'b0);
        for (int i = 0; i < 12; i++) model_cycle(1'b1);
        check("drain_owed", 64'(owed.size()), 64'd0);
        check("drain_outstanding", 64'(out_active), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
